// File: rtl/shift_rows_if.sv
// Stream interface for the ShiftRows stage: one 128-bit AES state per beat.
//   in_valid/in_ready  - upstream handshake; inverse/state_in qualified by in_valid
//   out_valid/out_ready - downstream handshake; state_out qualified by out_valid
//   master - the side that drives states in and consumes results
//   slave  - the shift_rows block itself
interface shift_rows_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid;
  logic               in_ready;
  logic               inverse;
  logic [STATE_W-1:0] state_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;

  modport master (
    output in_valid, inverse, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, inverse, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/shift_rows.sv
// Registered AES ShiftRows / InvShiftRows byte permutation, one output stage.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset; clears out_valid and state_out
//   bus    - shift_rows_if.slave: in_valid/in_ready/inverse/state_in in,
//            out_valid/out_ready/state_out out
// Byte k of a state lives at [127-8k -: 8], row k%4, column k/4.
// in_ready is combinational (!out_valid || out_ready); everything else is registered.
module shift_rows (
  input  logic         clk,
  input  logic         reset,
  shift_rows_if.slave  bus
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned N_ROWS  = 4;
  localparam int unsigned N_COLS  = 4;

  logic               out_valid_q;
  logic [STATE_W-1:0] state_q;
  logic               accept;

  // Row r rotates left by r (forward) or right by r (inverse).
  function automatic logic [STATE_W-1:0] permute(input logic [STATE_W-1:0] s,
                                                  input logic inv);
    logic [STATE_W-1:0] o;
    int unsigned        src_c;
    o = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      for (int unsigned c = 0; c < N_COLS; c++) begin
        src_c = inv ? ((c + N_COLS - r) % N_COLS) : ((c + r) % N_COLS);
        o[STATE_W-1-BYTE_W*(r+N_ROWS*c) -: BYTE_W] =
          s[STATE_W-1-BYTE_W*(r+N_ROWS*src_c) -: BYTE_W];
      end
    end
    return o;
  endfunction

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_q;

  // Output register: load on accept, otherwise drop valid once consumed.
  // state_in is only sampled on accept, so idle-cycle X never reaches state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      state_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      state_q     <= permute(bus.state_in, bus.inverse);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: directed AES vectors, back-to-back
// throughput, stall, asynchronous reset mid-stall, and a randomized
// valid/ready run, all scored against an independent table-driven model.
module tb_shift_rows;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_rows_if bus ();

  shift_rows dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // out byte k <- in byte FWD[k] for the forward direction.
  localparam int FWD [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_out   = 0;
  logic [127:0] exp_q [$];

  function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      if (!inv) o[127-8*k -: 8]      = s[127-8*FWD[k] -: 8];
      else      o[127-8*FWD[k] -: 8] = s[127-8*k -: 8];
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare completed outputs, then record accepted inputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_underflow", 128'(exp_q.size()), 128'd1);
        else                   check("sb_data", bus.state_out, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_perm(bus.state_in, bus.inverse));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state until accepted (bounded), then go idle with X data.
  task automatic send(input logic [127:0] d, input logic inv);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.state_in = d;
    bus.inverse  = inv;
    while (!acc && t < 50) begin
      acc = bus.in_ready;
      step();
      t++;
    end
    if (!acc) check("send_timeout", 128'(acc), 128'd1);
    bus.in_valid = 1'b0;
    bus.state_in = 'x;
    bus.inverse  = 1'bx;
  endtask

  localparam logic [127:0] V1 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] E1 = 128'h00050A0F_04090E03_080D0207_0C01060B;
  localparam logic [127:0] V2 = 128'h00010203_04050708_090A0080_C0E0F0F9;
  localparam logic [127:0] E2 = 128'h000500F9_040AF003_09E00208_C0010780;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d [4];
    logic [127:0] held;
    int           out_before;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inverse   = 1'b0;
    bus.state_in  = 'x;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_state_out", bus.state_out, 128'h0);
    check("rst_in_ready",  128'(bus.in_ready), 128'd1);
    step();
    step();
    reset = 1'b0;
    check("rel_in_ready", 128'(bus.in_ready), 128'd1);

    // Directed AES vectors, 1-cycle latency.
    bus.out_ready = 1'b1;
    send(V1, 1'b0);
    check("fwd1_valid", 128'(bus.out_valid), 128'd1);
    check("fwd1_data",  bus.state_out, E1);
    step();
    check("drain_valid", 128'(bus.out_valid), 128'd0);
    check("drain_keep",  bus.state_out, E1);
    send(V2, 1'b0);
    check("fwd2_data", bus.state_out, E2);
    send(E2, 1'b1);
    check("inv_data", bus.state_out, V2);
    step();

    // Back-to-back: one state per cycle with in_ready held high.
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.state_in = d[i];
      bus.inverse  = i[0];
      check("b2b_in_ready", 128'(bus.in_ready), 128'd1);
      step();
      check("b2b_valid", 128'(bus.out_valid), 128'd1);
      check("b2b_data",  bus.state_out, ref_perm(d[i], i[0]));
    end
    bus.in_valid = 1'b0;
    bus.state_in = 'x;
    step();

    // Stall: output held, new input refused until downstream is ready.
    bus.out_ready = 1'b0;
    send(V2, 1'b0);
    held = bus.state_out;
    check("stall_load", held, E2);
    bus.in_valid = 1'b1;
    bus.state_in = V1;
    bus.inverse  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 128'(bus.in_ready), 128'd0);
      step();
      check("stall_valid", 128'(bus.out_valid), 128'd1);
      check("stall_hold",  bus.state_out, E2);
    end
    bus.out_ready = 1'b1;
    step();
    check("stall_next", bus.state_out, E1);
    bus.in_valid = 1'b0;
    bus.state_in = 'x;
    step();

    // Asynchronous reset between edges while stalled.
    bus.out_ready = 1'b0;
    send(V1, 1'b1);
    check("pre_rst_valid", 128'(bus.out_valid), 128'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(bus.out_valid), 128'd0);
    check("async_rst_state", bus.state_out, 128'h0);
    exp_q.delete();
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
    step();
    check("post_rst_valid", 128'(bus.out_valid), 128'd0);

    // Random traffic with random backpressure and X on idle data.
    out_before = n_out;
    for (int i = 0; i < 200; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.inverse   = $urandom_range(0, 1) == 1;
      bus.state_in  = bus.in_valid ? {$urandom, $urandom, $urandom, $urandom} : 'x;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.state_in  = 'x;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rand_drained", 128'(exp_q.size()), 128'd0);
    check("rand_no_x", 128'($isunknown(bus.state_out)), 128'd0);
    check("rand_activity", 128'(n_out > out_before + 50), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
